// File: rtl/banked_ram_ctl.sv
`timescale 1ns/1ps
// banked_ram_ctl: NBANKS single-port read-first RAM banks behind a req/ready front end,
// with a two-stage aligned read mux, rvalid/err status and hardware zero-fill.
module banked_ram_ctl #(
  parameter int NBANKS  = 31,
  parameter int BANK_AW = 10,
  parameter int DATA_W  = 18,
  localparam int SEL_W  = (NBANKS > 1) ? $clog2(NBANKS) : 1,
  localparam int AW     = SEL_W + BANK_AW
) (
  input  logic              mclk,
  input  logic              rstn,
  input  logic              clr,
  input  logic              req,
  input  logic              wen,
  input  logic [AW-1:0]     addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              ready,
  output logic              busy,
  output logic              rvalid,
  output logic [DATA_W-1:0] rdata,
  output logic              err
);

  localparam int DEPTH = 1 << BANK_AW;
  localparam int NSLOT = 1 << SEL_W;
  localparam logic [SEL_W:0]   NB_W = (SEL_W + 1)'(NBANKS);
  localparam logic [BANK_AW-1:0] FMAX = '1;

  typedef enum logic {ST_INIT = 1'b0, ST_IDLE = 1'b1} state_t;

  state_t               r_state;
  logic [BANK_AW-1:0]   r_fcnt;
  logic                 r_ready;
  logic                 r_busy;

  logic                 r_v1, r_e1, r_v2, r_e2;
  logic [SEL_W-1:0]     r_sel1, r_sel2;
  logic                 r_rvalid, r_err;
  logic [DATA_W-1:0]    r_rdata;

  logic [SEL_W-1:0]     w_sel;
  logic [BANK_AW-1:0]   w_word;
  logic                 w_bad;
  logic                 w_acc;
  logic                 w_fill;
  logic [NSLOT-1:0][DATA_W-1:0] w_bank_q;

  assign w_sel  = addr[AW-1:BANK_AW];
  assign w_word = addr[BANK_AW-1:0];
  assign w_bad  = ({1'b0, w_sel} >= NB_W);
  // clr wins over a same-cycle request, so it blocks acceptance here
  assign w_acc  = req & r_ready & ~clr;
  assign w_fill = (r_state == ST_INIT);

  // Fill/idle sequencer with registered ready/busy
  always_ff @(posedge mclk or negedge rstn) begin
    if (!rstn) begin
      r_state <= ST_INIT;
      r_fcnt  <= '0;
      r_ready <= 1'b0;
      r_busy  <= 1'b1;
    end else begin
      case (r_state)
        ST_INIT: begin
          if (clr) begin
            r_fcnt <= '0;
          end else if (r_fcnt == FMAX) begin
            r_state <= ST_IDLE;
            r_fcnt  <= '0;
            r_ready <= 1'b1;
            r_busy  <= 1'b0;
          end else begin
            r_fcnt <= r_fcnt + 1'b1;
          end
        end
        ST_IDLE: begin
          if (clr) begin
            r_state <= ST_INIT;
            r_fcnt  <= '0;
            r_ready <= 1'b0;
            r_busy  <= 1'b1;
          end
        end
        default: begin
          r_state <= ST_INIT;
          r_fcnt  <= '0;
          r_ready <= 1'b0;
          r_busy  <= 1'b1;
        end
      endcase
    end
  end

  for (genvar k = 0; k < NSLOT; k++) begin : g_slot
    if (k < NBANKS) begin : g_bank
      logic [DATA_W-1:0] r_mem [DEPTH];
      logic [DATA_W-1:0] r_q0;
      logic [DATA_W-1:0] r_q1;
      logic              w_hit;

      assign w_hit = w_acc && (w_sel == SEL_W'(k));

      // Single-port read-first bank plus its output register
      always_ff @(posedge mclk) begin
        if (w_fill) begin
          r_mem[r_fcnt] <= '0;
        end else if (w_hit && wen) begin
          r_mem[w_word] <= wdata;
        end
        if (w_hit && !wen) begin
          r_q0 <= r_mem[w_word];
        end
        r_q1 <= r_q0;
      end

      assign w_bank_q[k] = r_q1;
    end else begin : g_empty
      assign w_bank_q[k] = '0;
    end
  end

  // Read/err pipeline: sel travels with the data so the mux never looks at live addr
  always_ff @(posedge mclk or negedge rstn) begin
    if (!rstn) begin
      r_v1     <= 1'b0;
      r_e1     <= 1'b0;
      r_sel1   <= '0;
      r_v2     <= 1'b0;
      r_e2     <= 1'b0;
      r_sel2   <= '0;
      r_rvalid <= 1'b0;
      r_err    <= 1'b0;
      r_rdata  <= '0;
    end else begin
      r_v1     <= w_acc & ~wen;
      r_e1     <= w_acc & w_bad;
      r_sel1   <= w_sel;
      r_v2     <= r_v1;
      r_e2     <= r_e1;
      r_sel2   <= r_sel1;
      r_rvalid <= r_v2;
      r_err    <= r_e2;
      if (r_v2) begin
        r_rdata <= r_e2 ? '0 : w_bank_q[r_sel2];
      end
    end
  end

  assign ready  = r_ready;
  assign busy   = r_busy;
  assign rvalid = r_rvalid;
  assign rdata  = r_rdata;
  assign err    = r_err;

endmodule
